reservation_station_issue: RTL

- Consumer end of the instruction-queue dispatch interface in the Tomasulo datapath.
- Accepts decoded instructions (opcode, RX, RY, RZ, immediate) and allocates them into a bank of reservation stations.
- Renames destinations through a register status table and wakes waiting operands from the common data bus (CDB).
- Dispatches ready entries to the functional unit and drives stall back to the queue when the bank is full.

---
 rtl/reservation_station_issue.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/reservation_station_issue.sv
// Reservation-station bank for a Tomasulo datapath: issues decoded instructions with
// register renaming, wakes operands from the CDB and dispatches ready entries to one FU.
module reservation_station_issue #(
  parameter int NUM_RS     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  instr_valid,
  input  logic [2:0]            opcode,
  input  logic [2:0]            RX,
  input  logic [2:0]            RY,
  input  logic [2:0]            RZ,
  input  logic [3:0]            immediate,
  output logic                  stall,
  output logic [2:0]            rf_addr_a,
  output logic [2:0]            rf_addr_b,
  input  logic [DATA_WIDTH-1:0] rf_data_a,
  input  logic [DATA_WIDTH-1:0] rf_data_b,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_value,
  output logic                  fu_valid,
  input  logic                  fu_ready,
  output logic [2:0]            fu_op,
  output logic [DATA_WIDTH-1:0] fu_vj,
  output logic [DATA_WIDTH-1:0] fu_vk,
  output logic [3:0]            fu_imm,
  output logic [TAG_WIDTH-1:0]  fu_tag
);
  localparam int IDX_W   = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int NUM_REG = 8;
  localparam int CAP_W   = TAG_WIDTH + DATA_WIDTH;
  localparam logic [2:0] OP_LD = 3'b010;
  localparam logic [2:0] OP_SD = 3'b011;

  // Control state: cleared by reset
  logic                  busy_q [NUM_RS];
  logic                  busy_d [NUM_RS];
  logic                  exec_q [NUM_RS];
  logic                  exec_d [NUM_RS];
  logic [TAG_WIDTH-1:0]  qj_q   [NUM_RS];
  logic [TAG_WIDTH-1:0]  qj_d   [NUM_RS];
  logic [TAG_WIDTH-1:0]  qk_q   [NUM_RS];
  logic [TAG_WIDTH-1:0]  qk_d   [NUM_RS];
  logic [TAG_WIDTH-1:0]  stat_q [NUM_REG];
  logic [TAG_WIDTH-1:0]  stat_d [NUM_REG];

  // Payload: only meaningful while the entry is busy, so never reset
  logic [2:0]            op_q   [NUM_RS];
  logic [2:0]            op_d   [NUM_RS];
  logic [DATA_WIDTH-1:0] vj_q   [NUM_RS];
  logic [DATA_WIDTH-1:0] vj_d   [NUM_RS];
  logic [DATA_WIDTH-1:0] vk_q   [NUM_RS];
  logic [DATA_WIDTH-1:0] vk_d   [NUM_RS];
  logic [3:0]            imm_q  [NUM_RS];
  logic [3:0]            imm_d  [NUM_RS];

  logic                  cdb_hit;
  logic                  any_free;
  logic [IDX_W-1:0]      free_idx;
  logic [IDX_W-1:0]      sel_idx;
  logic                  issue_fire;
  logic                  writes_dest;
  logic                  dispatch_fire;
  logic [TAG_WIDTH-1:0]  new_tag;
  logic [CAP_W-1:0]      cap_j;
  logic [CAP_W-1:0]      cap_k;

  function automatic logic [TAG_WIDTH-1:0] idx_to_tag(input int idx);
    return TAG_WIDTH'(idx + 1);
  endfunction

  // Returns {Q, V}: register value, same-cycle CDB bypass, or the pending tag.
  function automatic logic [CAP_W-1:0] capture_operand(
    input logic [TAG_WIDTH-1:0]  src_tag,
    input logic [DATA_WIDTH-1:0] rf_val,
    input logic                  bcast,
    input logic [TAG_WIDTH-1:0]  bcast_tag,
    input logic [DATA_WIDTH-1:0] bcast_val
  );
    if (src_tag == '0)
      return {{TAG_WIDTH{1'b0}}, rf_val};
    else if (bcast && (bcast_tag == src_tag))
      return {{TAG_WIDTH{1'b0}}, bcast_val};
    else
      return {src_tag, rf_val};
  endfunction

  // Tag 0 means "ready", so a broadcast of tag 0 must never match anything.
  assign cdb_hit   = cdb_valid && (cdb_tag != '0);
  assign rf_addr_a = RY;
  assign rf_addr_b = (opcode == OP_SD) ? RX : RZ;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    fu_valid = 1'b0;
    sel_idx  = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (busy_q[i] && !exec_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0)) begin
        fu_valid = 1'b1;
        sel_idx  = IDX_W'(i);
      end
    end
  end

  assign stall         = !any_free;
  assign issue_fire    = instr_valid && !stall && !opcode[2];
  assign writes_dest   = issue_fire && (opcode != OP_SD);
  assign dispatch_fire = fu_valid && fu_ready;
  assign new_tag       = idx_to_tag(int'(free_idx));
  assign cap_j = capture_operand(stat_q[RY], rf_data_a, cdb_hit, cdb_tag, cdb_value);
  assign cap_k = (opcode == OP_LD) ? '0
               : capture_operand(stat_q[rf_addr_b], rf_data_b, cdb_hit, cdb_tag, cdb_value);

  always_comb begin
    fu_op  = '0;
    fu_vj  = '0;
    fu_vk  = '0;
    fu_imm = '0;
    fu_tag = '0;
    if (fu_valid) begin
      fu_op  = op_q[sel_idx];
      fu_vj  = vj_q[sel_idx];
      fu_vk  = vk_q[sel_idx];
      fu_imm = imm_q[sel_idx];
      fu_tag = (op_q[sel_idx] == OP_SD) ? '0 : idx_to_tag(int'(sel_idx));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RS; i++) begin
      busy_d[i] = busy_q[i];
      exec_d[i] = exec_q[i];
      qj_d[i]   = qj_q[i];
      qk_d[i]   = qk_q[i];
      op_d[i]   = op_q[i];
      vj_d[i]   = vj_q[i];
      vk_d[i]   = vk_q[i];
      imm_d[i]  = imm_q[i];
      if (cdb_hit && busy_q[i]) begin
        if (qj_q[i] == cdb_tag) begin
          qj_d[i] = '0;
          vj_d[i] = cdb_value;
        end
        if (qk_q[i] == cdb_tag) begin
          qk_d[i] = '0;
          vk_d[i] = cdb_value;
        end
        if (exec_q[i] && (idx_to_tag(i) == cdb_tag)) begin
          busy_d[i] = 1'b0;
          exec_d[i] = 1'b0;
        end
      end
      // Stores produce no result, so they retire as soon as the FU takes them.
      if (dispatch_fire && (sel_idx == IDX_W'(i))) begin
        if (op_q[i] == OP_SD) busy_d[i] = 1'b0;
        else                  exec_d[i] = 1'b1;
      end
      if (issue_fire && (free_idx == IDX_W'(i))) begin
        busy_d[i]           = 1'b1;
        exec_d[i]           = 1'b0;
        op_d[i]             = opcode;
        imm_d[i]            = immediate;
        {qj_d[i], vj_d[i]}  = cap_j;
        {qk_d[i], vk_d[i]}  = cap_k;
      end
    end
    // Issue rename is applied after the CDB clear so it wins on the same register.
    for (int r = 0; r < NUM_REG; r++) begin
      stat_d[r] = (cdb_hit && (stat_q[r] == cdb_tag)) ? '0 : stat_q[r];
      if (writes_dest && (RX == 3'(r))) stat_d[r] = new_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_RS; i++) begin
        busy_q[i] <= 1'b0;
        exec_q[i] <= 1'b0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
      end
      for (int r = 0; r < NUM_REG; r++) stat_q[r] <= '0;
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        busy_q[i] <= busy_d[i];
        exec_q[i] <= exec_d[i];
        qj_q[i]   <= qj_d[i];
        qk_q[i]   <= qk_d[i];
      end
      for (int r = 0; r < NUM_REG; r++) stat_q[r] <= stat_d[r];
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_RS; i++) begin
      op_q[i]  <= op_d[i];
      vj_q[i]  <= vj_d[i];
      vk_q[i]  <= vk_d[i];
      imm_q[i] <= imm_d[i];
    end
  end

endmodule
